// File: rtl/hangman_game_engine_if.sv
// rtl/hangman_game_engine_if.sv - control/guess handshake between the input source and the game engine
interface hangman_game_engine_if;
  logic       new_game;
  logic [2:0] word_sel;
  logic       guess_valid;
  logic [7:0] guess_char;
  logic       busy;

  modport master (output new_game, output word_sel, output guess_valid, output guess_char, input busy);
  modport slave  (input new_game, input word_sel, input guess_valid, input guess_char, output busy);
endinterface

// File: rtl/hangman_game_engine.sv
// rtl/hangman_game_engine.sv - hangman game logic feeding ten display characters and the wrong-guess count
module hangman_game_engine #(
  parameter int         MAX_WRONG  = 6,
  parameter logic [7:0] BLANK_CHAR = 8'h5F,
  parameter logic [7:0] PAD_CHAR   = 8'h20
) (
  input  logic                        clk,
  input  logic                        clr,
  hangman_game_engine_if.slave        gif,
  output logic [7:0]                  letter_one,
  output logic [7:0]                  letter_two,
  output logic [7:0]                  letter_three,
  output logic [7:0]                  letter_four,
  output logic [7:0]                  letter_five,
  output logic [7:0]                  letter_six,
  output logic [7:0]                  letter_seven,
  output logic [7:0]                  letter_eight,
  output logic [7:0]                  letter_nine,
  output logic [7:0]                  letter_ten,
  output logic [3:0]                  incorrect,
  output logic                        game_won,
  output logic                        game_lost
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_CHECK, S_WON, S_LOST} state_t;

  localparam logic [3:0] MAX_W = 4'(MAX_WRONG);

  state_t      state, state_nxt;
  logic [2:0]  sel_q;
  logic [79:0] word_q;        // position 1 occupies the top byte
  logic [3:0]  len_q;
  logic [9:0]  rev_q;         // bit i = position i+1 revealed
  logic [25:0] guessed_q;     // bit 0 = 'A'
  logic [3:0]  incorrect_q;
  logic [7:0]  guess_q;
  logic [79:0] disp_q;

  logic [79:0] rom_word;
  logic [3:0]  rom_len;
  logic [7:0]  guess_fold;
  logic        guess_ok;
  logic [4:0]  guess_idx;
  logic        dup;
  logic [9:0]  match;
  logic [9:0]  len_mask;
  logic [9:0]  rev_chk;
  logic [3:0]  inc_chk;
  logic        won_c;
  logic        lost_c;
  logic [79:0] disp_load;
  logic [79:0] disp_chk;

  function automatic logic [7:0] char_at(input logic [79:0] w, input int i);
    return w[79-8*i -: 8];
  endfunction

  // word ROM; unused tail bytes are zero and never displayed
  always_comb begin
    rom_word = 80'h0;
    rom_len  = 4'd0;
    case (sel_q)
      3'd0: begin rom_word = {"VERILOG", 24'h0};   rom_len = 4'd7; end
      3'd1: begin rom_word = {"HANGMAN", 24'h0};   rom_len = 4'd7; end
      3'd2: begin rom_word = {"FPGA", 48'h0};      rom_len = 4'd4; end
      3'd3: begin rom_word = {"XILINX", 32'h0};    rom_len = 4'd6; end
      3'd4: begin rom_word = {"CLOCK", 40'h0};     rom_len = 4'd5; end
      3'd5: begin rom_word = {"REGISTER", 16'h0};  rom_len = 4'd8; end
      3'd6: begin rom_word = {"FLIPFLOP", 16'h0};  rom_len = 4'd8; end
      default: begin rom_word = {"SYNTHESIS", 8'h0}; rom_len = 4'd9; end
    endcase
  end

  // fold lowercase to uppercase and qualify the incoming guess as a letter
  always_comb begin
    guess_fold = gif.guess_char;
    if (gif.guess_char >= 8'h61 && gif.guess_char <= 8'h7A)
      guess_fold = gif.guess_char & 8'hDF;
    guess_ok = (guess_fold >= 8'h41) && (guess_fold <= 8'h5A);
  end

  // evaluate the latched guess against the word and prepare both display images
  always_comb begin
    guess_idx = guess_q[4:0] - 5'd1;
    dup       = guessed_q[guess_idx];
    len_mask  = (10'd1 << len_q) - 10'd1;
    match     = '0;
    for (int i = 0; i < 10; i++)
      match[i] = (4'(i) < len_q) && (char_at(word_q, i) == guess_q);
    rev_chk = dup ? rev_q : (rev_q | match);
    if (dup || (|match))
      inc_chk = incorrect_q;
    else if (incorrect_q >= MAX_W)
      inc_chk = MAX_W;
    else
      inc_chk = incorrect_q + 4'd1;
    won_c  = &(rev_chk | ~len_mask);
    lost_c = inc_chk >= MAX_W;
    disp_load = '0;
    disp_chk  = '0;
    for (int i = 0; i < 10; i++) begin
      disp_load[79-8*i -: 8] = (4'(i) < rom_len) ? BLANK_CHAR : PAD_CHAR;
      if (4'(i) >= len_q)
        disp_chk[79-8*i -: 8] = PAD_CHAR;
      else if (rev_chk[i] || lost_c)
        disp_chk[79-8*i -: 8] = char_at(word_q, i);
      else
        disp_chk[79-8*i -: 8] = BLANK_CHAR;
    end
  end

  // state register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // next-state logic; new_game overrides everything
  always_comb begin
    state_nxt = state;
    if (gif.new_game) begin
      state_nxt = S_LOAD;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_IDLE;
        S_LOAD:  state_nxt = S_PLAY;
        S_PLAY:  if (gif.guess_valid && guess_ok) state_nxt = S_CHECK;
        S_CHECK: state_nxt = won_c ? S_WON : (lost_c ? S_LOST : S_PLAY);
        S_WON:   state_nxt = S_WON;
        S_LOST:  state_nxt = S_LOST;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // status outputs decoded from the state
  always_comb begin
    gif.busy  = (state == S_LOAD) || (state == S_CHECK);
    game_won  = (state == S_WON);
    game_lost = (state == S_LOST);
  end

  // game datapath: word load, guess latch, reveal/penalty update and registered display
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sel_q       <= 3'd0;
      word_q      <= '0;
      len_q       <= 4'd0;
      rev_q       <= '0;
      guessed_q   <= '0;
      incorrect_q <= 4'd0;
      guess_q     <= 8'd0;
      disp_q      <= {10{PAD_CHAR}};
    end else if (gif.new_game) begin
      sel_q <= gif.word_sel;
    end else begin
      case (state)
        S_LOAD: begin
          word_q      <= rom_word;
          len_q       <= rom_len;
          rev_q       <= '0;
          guessed_q   <= '0;
          incorrect_q <= 4'd0;
          disp_q      <= disp_load;
        end
        S_PLAY: begin
          if (gif.guess_valid && guess_ok) guess_q <= guess_fold;
        end
        S_CHECK: begin
          guessed_q[guess_idx] <= 1'b1;
          rev_q                <= rev_chk;
          incorrect_q          <= inc_chk;
          disp_q               <= disp_chk;
        end
        default: ;
      endcase
    end
  end

  assign letter_one   = disp_q[79:72];
  assign letter_two   = disp_q[71:64];
  assign letter_three = disp_q[63:56];
  assign letter_four  = disp_q[55:48];
  assign letter_five  = disp_q[47:40];
  assign letter_six   = disp_q[39:32];
  assign letter_seven = disp_q[31:24];
  assign letter_eight = disp_q[23:16];
  assign letter_nine  = disp_q[15:8];
  assign letter_ten   = disp_q[7:0];
  assign incorrect    = incorrect_q;

endmodule

// File: tb/tb_hangman_game_engine.sv
// tb/tb_hangman_game_engine.sv - directed self-checking bench for hangman_game_engine
module tb_hangman_game_engine;
  logic       clk;
  logic       clr;
  logic [7:0] letter_one, letter_two, letter_three, letter_four, letter_five;
  logic [7:0] letter_six, letter_seven, letter_eight, letter_nine, letter_ten;
  logic [3:0] incorrect;
  logic       game_won, game_lost;

  int n_cmp = 0;
  int n_bad = 0;

  hangman_game_engine_if gif ();

  hangman_game_engine dut (
    .clk          (clk),
    .clr          (clr),
    .gif          (gif.slave),
    .letter_one   (letter_one),
    .letter_two   (letter_two),
    .letter_three (letter_three),
    .letter_four  (letter_four),
    .letter_five  (letter_five),
    .letter_six   (letter_six),
    .letter_seven (letter_seven),
    .letter_eight (letter_eight),
    .letter_nine  (letter_nine),
    .letter_ten   (letter_ten),
    .incorrect    (incorrect),
    .game_won     (game_won),
    .game_lost    (game_lost)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // compare one observed value against its expectation
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] board();
    return {letter_one, letter_two, letter_three, letter_four, letter_five,
            letter_six, letter_seven, letter_eight, letter_nine, letter_ten};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [2:0] sel);
    gif.new_game = 1'b1;
    gif.word_sel = sel;
    tick();
    gif.new_game = 1'b0;
    tick();
  endtask

  task automatic guess(input logic [7:0] c);
    gif.guess_valid = 1'b1;
    gif.guess_char  = c;
    tick();
    gif.guess_valid = 1'b0;
    tick();
  endtask

  initial begin
    clr = 1'b0;
    gif.new_game = 1'b0;
    gif.word_sel = 3'd0;
    gif.guess_valid = 1'b0;
    gif.guess_char = 8'h00;
    tick();
    tick();
    chk("rst_letters", board(), "          ");
    chk("rst_incorrect", 80'(incorrect), 80'd0);
    chk("rst_won", 80'(game_won), 80'd0);
    chk("rst_lost", 80'(game_lost), 80'd0);
    chk("rst_busy", 80'(gif.busy), 80'd0);
    clr = 1'b1;
    tick();

    // FPGA board
    gif.new_game = 1'b1;
    gif.word_sel = 3'd2;
    tick();
    gif.new_game = 1'b0;
    chk("load_busy", 80'(gif.busy), 80'd1);
    tick();
    chk("fpga_blank", board(), "____      ");
    chk("fpga_inc0", 80'(incorrect), 80'd0);
    chk("fpga_busy0", 80'(gif.busy), 80'd0);

    gif.guess_valid = 1'b1;
    gif.guess_char  = 8'h67;
    tick();
    gif.guess_valid = 1'b0;
    chk("check_busy", 80'(gif.busy), 80'd1);
    chk("g_not_yet", board(), "____      ");
    tick();
    chk("g_reveal", board(), "__G_      ");
    chk("g_inc", 80'(incorrect), 80'd0);

    guess("Z");
    chk("z1_inc", 80'(incorrect), 80'd1);
    guess("Z");
    chk("z2_inc", 80'(incorrect), 80'd1);
    chk("z2_board", board(), "__G_      ");

    gif.guess_valid = 1'b1;
    gif.guess_char  = "5";
    tick();
    gif.guess_valid = 1'b0;
    chk("digit_no_check", 80'(gif.busy), 80'd0);
    tick();
    chk("digit_inc", 80'(incorrect), 80'd1);

    guess("F");
    guess("p");
    chk("fp_board", board(), "FPG_      ");
    chk("fp_won", 80'(game_won), 80'd0);
    guess("A");
    chk("won_board", board(), "FPGA      ");
    chk("won_flag", 80'(game_won), 80'd1);
    chk("won_busy", 80'(gif.busy), 80'd0);
    guess("Q");
    chk("won_q_inc", 80'(incorrect), 80'd1);
    chk("won_q_board", board(), "FPGA      ");
    chk("won_hold", 80'(game_won), 80'd1);

    // CLOCK, lose
    start(3'd4);
    chk("clock_blank", board(), "_____     ");
    chk("clock_inc0", 80'(incorrect), 80'd0);
    chk("clock_won0", 80'(game_won), 80'd0);
    guess("Z"); chk("w1", 80'(incorrect), 80'd1);
    guess("Q"); chk("w2", 80'(incorrect), 80'd2);
    guess("X"); chk("w3", 80'(incorrect), 80'd3);
    guess("J"); chk("w4", 80'(incorrect), 80'd4);
    guess("V"); chk("w5", 80'(incorrect), 80'd5);
    chk("w5_lost", 80'(game_lost), 80'd0);
    chk("w5_board", board(), "_____     ");
    guess("W");
    chk("w6_inc", 80'(incorrect), 80'd6);
    chk("w6_lost", 80'(game_lost), 80'd1);
    chk("w6_board", board(), "CLOCK     ");
    guess("A");
    chk("w7_inc", 80'(incorrect), 80'd6);
    chk("w7_lost", 80'(game_lost), 80'd1);

    // new_game together with a guess
    start(3'd0);
    chk("lost_cleared", 80'(game_lost), 80'd0);
    guess("e");
    chk("verilog_e", board(), "_E_____   ");
    gif.new_game    = 1'b1;
    gif.word_sel    = 3'd1;
    gif.guess_valid = 1'b1;
    gif.guess_char  = "H";
    tick();
    gif.new_game    = 1'b0;
    gif.guess_valid = 1'b0;
    tick();
    chk("ng_drop_board", board(), "_______   ");
    chk("ng_drop_inc", 80'(incorrect), 80'd0);
    guess("a");
    chk("hangman_a", board(), "_A___A_   ");
    guess("Z");
    chk("hangman_z", 80'(incorrect), 80'd1);

    // asynchronous reset in CHECK
    gif.guess_valid = 1'b1;
    gif.guess_char  = "N";
    tick();
    gif.guess_valid = 1'b0;
    chk("pre_rst_busy", 80'(gif.busy), 80'd1);
    clr = 1'b0;
    #2;
    chk("arst_letters", board(), "          ");
    chk("arst_inc", 80'(incorrect), 80'd0);
    chk("arst_busy", 80'(gif.busy), 80'd0);
    chk("arst_won", 80'(game_won), 80'd0);
    chk("arst_lost", 80'(game_lost), 80'd0);
    tick();
    clr = 1'b1;
    tick();
    start(3'd7);
    chk("synth_blank", board(), "_________ ");
    guess("s");
    chk("synth_s", board(), "S_____S_S ");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hangman_game_engine.md
Name: hangman_game_engine

Overview:
- Game-logic stage directly upstream of the VGA interpreter.
- Holds the secret word, accepts guessed letters and tracks revealed positions and the wrong-guess count.
- Drives the ten 8-bit display characters and the 4-bit incorrect count that the VGA interpreter consumes.
- Runs on the 50 MHz master clock. Guess strobes arrive already debounced, one cycle wide.

Parameters:
- MAX_WRONG, 6: wrong guesses that lose the game; legal range 1..15.
- BLANK_CHAR, 8'h5F: ASCII code shown for an unrevealed position ('_').
- PAD_CHAR, 8'h20: ASCII code shown for positions beyond the word length (space).

Ports:
- clk, input, 1: master clock, 50 MHz.
- clr, input, 1: asynchronous, active-low reset.
- new_game, input, 1: one-cycle pulse; starts a game with word word_sel.
- word_sel, input, 3: ROM word index, sampled when new_game=1.
- guess_valid, input, 1: one-cycle pulse; guess_char is valid.
- guess_char, input, 8: ASCII guess.
- letter_one … letter_ten, output, 8 each: display characters, position 1 = leftmost.
- incorrect, output, 4: wrong guesses so far.
- game_won, output, 1: high in WON state.
- game_lost, output, 1: high in LOST state.
- busy, output, 1: high in LOAD or CHECK.

Behaviour:
- Reset (clr=0, async) values:
  - state=IDLE.
  - All letter_* = PAD_CHAR.
  - incorrect=0; game_won=0; game_lost=0; busy=0.
  - guessed mask (26 bits) = 0.
- Word ROM (uppercase ASCII, positions past the length = pad):
  - 0 VERILOG(7), 1 HANGMAN(7), 2 FPGA(4), 3 XILINX(6)
  - 4 CLOCK(5), 5 REGISTER(8), 6 FLIPFLOP(8), 7 SYNTHESIS(9)
- FSM states: IDLE, LOAD, PLAY, CHECK, WON, LOST.
- new_game=1 in any state:
  - Next state LOAD; word_sel latched.
  - Pending guess in the same cycle is dropped.
  - new_game has priority over every other transition, including mid-CHECK.
- LOAD (1 cycle):
  - Copy the ROM word and its length into registers; clear revealed mask, guessed mask, incorrect, game_won, game_lost.
  - Next state PLAY.
  - Display at PLAY entry: BLANK_CHAR for positions < length, PAD_CHAR otherwise.
- PLAY, guess_valid=1:
  - Fold guess_char 0x61–0x7A to uppercase by clearing bit 5; latch it; go to CHECK.
  - Characters outside A–Z after folding: ignored, stay in PLAY, no state change.
- PLAY, guess_valid=0: hold.
- CHECK (1 cycle):
  - Letter already in guessed mask: no effect (no penalty, no reveal).
  - Otherwise set its guessed bit and compare against all 10 positions in parallel.
  - Any match: set revealed bits for every matching position.
  - No match: incorrect += 1.
  - Next state:
    - WON if all positions < length are revealed.
    - Else LOST if incorrect reaches MAX_WRONG.
    - Else PLAY.
- Latency: guess_valid in cycle N → updated letter_*/incorrect visible in cycle N+2; game_won/game_lost asserted in the same cycle.
- Guesses with guess_valid in IDLE, LOAD, CHECK, WON or LOST are ignored. No buffering; busy tells the upstream source to hold off.
- WON: letters as revealed (whole word); holds until new_game or reset.
- LOST: all positions < length display the word (full reveal); incorrect holds MAX_WRONG; holds until new_game or reset.
- incorrect never exceeds MAX_WRONG.
- Display mux is a registered function of revealed mask, word registers, length and state. letter_* change only on the clock edge after LOAD or CHECK.
- Reset asserted mid-game returns every output to its reset value asynchronously.

Test Plan:
- Reset, then new_game with word_sel=2:
  - Two cycles later letter_one..four=0x5F, letter_five..ten=0x20, incorrect=0, busy back to 0.
- In PLAY, guess 'g' (0x67) at cycle N:
  - Cycle N+2: letter_three=0x47 ('G'); other positions unchanged; incorrect=0.
- Guess 'Z' twice:
  - incorrect=1 after the first; still 1 after the repeat.
  - Guess '5' (0x35): no change, no CHECK entry.
- On FPGA, guess G then F, P, A:
  - After A: letters "FPGA", game_won=1.
  - A further 'Q' guess leaves incorrect and letters unchanged.
- word_sel=4 (CLOCK), six wrong guesses (Z,Q,X,J,V,W):
  - incorrect=6, game_lost=1, letters show "CLOCK".
  - A 7th guess does not raise incorrect.
- Mid-game checks:
  - new_game asserted together with guess_valid: guess dropped, fresh board.
  - clr pulled low mid-CHECK: all outputs immediately at reset values.
